// File: rtl/imem_sync.sv
// Synchronous-read instruction store: zero-fill after reset, valid/ready loader, 1-cycle fetch with stall hold.
// Optional per-word parity storage and checking enabled by defining IMEM_PARITY_EN.
module imem_sync #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              ld_par_flip,
  input  logic              reload,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_perr,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = DEPTH[ADDR_W:0];
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ld_fire;
  logic              ld_in_range;
  logic              rd_in_range;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  assign ld_fire     = ld_valid && ld_ready;
  assign ld_in_range = ({1'b0, ld_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, fetch_addr} < DEPTH_L);
  assign rd_idx      = fetch_addr[IDX_W-1:0];
  assign rd_word     = rd_in_range ? mem[rd_idx] : '0;

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic wr_par;
  logic rd_perr;
  logic perr_p1;

  assign rd_perr    = rd_in_range ? (par_mem[rd_idx] ^ (^rd_word)) : 1'b0;
  assign fetch_perr = perr_p1;
`else
  logic unused_par_flip;

  assign unused_par_flip = ld_par_flip;
  assign fetch_perr      = 1'b0;
`endif

  // Single write port shared by the zero-fill sweep and the loader; the two never overlap in time.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
`ifdef IMEM_PARITY_EN
    wr_par  = 1'b0;
`endif
    case (state)
      S_INIT: begin
        wr_en  = 1'b1;
        wr_idx = clr_cnt;
      end
      S_LOAD: begin
        if (ld_fire && ld_in_range) begin
          wr_en   = 1'b1;
          wr_idx  = ld_addr[IDX_W-1:0];
          wr_data = ld_data;
`ifdef IMEM_PARITY_EN
          wr_par  = (^ld_data) ^ ld_par_flip;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
`ifdef IMEM_PARITY_EN
      par_mem[wr_idx] <= wr_par;
`endif
    end
  end

  // Control and fetch output stage (p1): reset clears outputs so the core never sees stale words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      clr_cnt  <= '0;
      ld_ready <= 1'b0;
      busy     <= 1'b1;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
`ifdef IMEM_PARITY_EN
      perr_p1  <= 1'b0;
`endif
    end else begin
      case (state)
        S_INIT: begin
          if (clr_cnt == LAST_IDX) begin
            state    <= S_LOAD;
            ld_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          vld_p1 <= 1'b0;
          if (ld_fire && ld_last) begin
            state    <= S_RUN;
            ld_ready <= 1'b0;
          end
        end
        S_RUN: begin
          if (reload) begin
            state    <= S_LOAD;
            ld_ready <= 1'b1;
            vld_p1   <= 1'b0;
          end else if (!fetch_stall) begin
            vld_p1 <= fetch_req;
            if (fetch_req) begin
              data_p1 <= rd_word;
`ifdef IMEM_PARITY_EN
              perr_p1 <= rd_perr;
`endif
            end
          end
        end
        default: begin
          state    <= S_INIT;
          clr_cnt  <= '0;
          ld_ready <= 1'b0;
          busy     <= 1'b1;
          vld_p1   <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid = vld_p1;
  assign fetch_data  = data_p1;

endmodule
